block_solver_mc: RTL and testbench
==================================

BLOCK_SOLVER_MC -- requirements
Module: block_solver_mc

Interface
REQ-001 Parameter NUM_CORES, default 4, SHALL set the number of attached hash cores (1..16).
REQ-002 Parameter NONCE_W, default 32, SHALL set the nonce width.
REQ-003 clk  input  1  SHALL be the single clock.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  input  1  SHALL be a one-cycle job launch pulse.
REQ-006 abort  input  1  SHALL cancel the current job.
REQ-007 midstate  input  256  SHALL carry the SHA-256 midstate.
REQ-008 header_leftovers  input  96  SHALL carry the header tail.
REQ-009 target  input  256  SHALL carry the unsigned difficulty target.
REQ-010 nonce_first, nonce_last  input  NONCE_W each  SHALL give the inclusive search range.
REQ-011 state_out  output  2  SHALL report job state: IDLE=0, RUNNING=1, FOUND=2, EXHAUSTED=3.
REQ-012 nonce  output  NONCE_W  SHALL hold the winning nonce.
REQ-013 core_midstate / core_tail  output  256 / 96  SHALL carry the latched job data shared by all cores.
REQ-014 core_valid / core_ready  output / input  NUM_CORES  SHALL form a per-core issue handshake.
REQ-015 core_nonce  output  NUM_CORES*NONCE_W  SHALL carry the per-core issued nonce.
REQ-016 res_valid  input  NUM_CORES, res_hash  input  NUM_CORES*256, res_nonce  input  NUM_CORES*NONCE_W  SHALL carry the per-core results.

Function
REQ-017 In IDLE, FOUND or EXHAUSTED, start SHALL latch midstate, header_leftovers, target and the range, then enter RUNNING on the next cycle; start while RUNNING SHALL be ignored.
REQ-018 If nonce_first > nonce_last at start, the block SHALL enter EXHAUSTED next cycle with no issue.
REQ-019 While RUNNING, each cycle every core i with core_ready[i]=1 SHALL get core_valid[i]=1 and core_nonce = next + (number of ready cores with index < i), provided that value is <= nonce_last.
REQ-020 next SHALL advance by the number of nonces issued that cycle; next and the range compare SHALL be NONCE_W+1 bits wide, so the range 0..2^NONCE_W-1 terminates without wrap.
REQ-021 A result SHALL match when res_valid[i]=1 and res_hash[i] <= latched target (256-bit unsigned).
REQ-022 On a match, state SHALL go to FOUND next cycle with nonce = res_nonce of the lowest-index matching core, and issue SHALL stop that same cycle.
REQ-023 An outstanding counter SHALL add nonces issued and subtract results returned, in the same cycle.
REQ-024 When every nonce is issued, outstanding reaches 0, and no match occurred, state SHALL go to EXHAUSTED next cycle.
REQ-025 If a match and the final result arrive in the same cycle, FOUND SHALL take priority over EXHAUSTED.
REQ-026 Results arriving in FOUND or IDLE SHALL be ignored for matching and SHALL NOT change nonce.
REQ-027 abort SHALL force IDLE next cycle and drop all core_valid; abort SHALL beat start in the same cycle.
REQ-028 nonce SHALL hold its value until the next start.

Reset
REQ-029 rst SHALL set state_out=IDLE, nonce=0, core_valid=0, the outstanding counter=0, next=0, and all latched job registers to 0.
REQ-030 rst asserted mid-job SHALL take priority over every other input, and the block SHALL issue nothing on the cycle after rst deasserts.

Structure
REQ-031 Package miner_pkg SHALL hold the state enum, the SHA-256 width constants (256, 96) and the default NONCE_W.
REQ-032 Sub-module hash_target_cmp (one 256-bit <= comparator) SHALL be instantiated once per core.

Verification
REQ-033 NUM_CORES=4, all ready, range 0..11, no match -> core nonces 0-3, 4-7, 8-11 on three consecutive cycles; state EXHAUSTED after the last result.
REQ-034 Cores 1 and 3 ready only, range 5..9 -> core1=5, core3=6 per cycle progression 5,6 / 7,8 / 9 (core1 only); no issue above 9.
REQ-035 Cores 0 and 2 both match in one cycle with res_nonce 0x20 and 0x10 -> FOUND, nonce=0x20.
REQ-036 Range 0xFFFFFFFE..0xFFFFFFFF -> exactly two nonces issued, then EXHAUSTED, with no wrap to 0.
REQ-037 nonce_first=10, nonce_last=3 -> EXHAUSTED one cycle after start; core_valid stays 0.
REQ-038 abort and start asserted together while RUNNING -> IDLE next cycle, core_valid=0; the following rst keeps all outputs at reset values.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and width constants for the multi-core block solver.
// The job state encoding is visible on state_out, so its values are fixed.
package miner_pkg;

    localparam int HASH_W          = 256;
    localparam int TAIL_W          = 96;
    localparam int NONCE_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_FOUND     = 2'd2,
        ST_EXHAUSTED = 2'd3
    } job_state_t;

endpackage

// File: rtl/hash_target_cmp.sv
// One unsigned 256-bit "hash <= target" comparator, instantiated once per hash core.
module hash_target_cmp
    import miner_pkg::*;
(
    input  logic [HASH_W-1:0] hash,
    input  logic [HASH_W-1:0] target,
    output logic              le
);

    assign le = (hash <= target);

endmodule

// File: rtl/block_solver_mc.sv
// Nonce dispatcher for NUM_CORES hash cores: hands out a nonce range, tracks
// results in flight and reports the lowest-index winning nonce or exhaustion.
module block_solver_mc
    import miner_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = NONCE_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [HASH_W-1:0]            midstate,
    input  logic [TAIL_W-1:0]            header_leftovers,
    input  logic [HASH_W-1:0]            target,
    input  logic [NONCE_W-1:0]           nonce_first,
    input  logic [NONCE_W-1:0]           nonce_last,
    output logic [1:0]                   state_out,
    output logic [NONCE_W-1:0]           nonce,
    output logic [HASH_W-1:0]            core_midstate,
    output logic [TAIL_W-1:0]            core_tail,
    output logic [NUM_CORES-1:0]         core_valid,
    input  logic [NUM_CORES-1:0]         core_ready,
    output logic [NUM_CORES*NONCE_W-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]         res_valid,
    input  logic [NUM_CORES*HASH_W-1:0]  res_hash,
    input  logic [NUM_CORES*NONCE_W-1:0] res_nonce
);

    // One extra bit so the top-of-range case terminates instead of wrapping to 0.
    localparam int CW = NONCE_W + 1;

    job_state_t         state, state_d;
    logic [CW-1:0]      next_q, last_q, next_d;
    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic [CW-1:0]      issued_cnt, returned_cnt;
    logic [CW-1:0]      rank, cand;
    logic [HASH_W-1:0]  midstate_q, target_q;
    logic [TAIL_W-1:0]  tail_q;
    logic [NONCE_W-1:0] nonce_q, match_nonce;
    logic [NUM_CORES-1:0] hit;
    logic               match, launch, running;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_cmp
        hash_target_cmp u_cmp (
            .hash   (res_hash[g*HASH_W +: HASH_W]),
            .target (target_q),
            .le     (hit[g])
        );
    end

    assign running = (state == ST_RUNNING) && !abort && !rst;

    // Descending scan so the lowest-index matching core wins.
    always_comb begin
        match        = 1'b0;
        match_nonce  = '0;
        returned_cnt = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (running && res_valid[i]) begin
                returned_cnt = returned_cnt + CW'(1);
                if (hit[i]) begin
                    match       = 1'b1;
                    match_nonce = res_nonce[i*NONCE_W +: NONCE_W];
                end
            end
        end
    end

    // Ready cores take consecutive nonces in index order; a match stops issue at once.
    always_comb begin
        core_valid = '0;
        core_nonce = '0;
        issued_cnt = '0;
        rank       = '0;
        cand       = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = next_q + rank;
            if (core_ready[i]) begin
                if (running && !match && (cand <= last_q)) begin
                    core_valid[i]                      = 1'b1;
                    core_nonce[i*NONCE_W +: NONCE_W]   = cand[NONCE_W-1:0];
                    issued_cnt                         = issued_cnt + CW'(1);
                end
                rank = rank + CW'(1);
            end
        end
    end

    assign next_d        = next_q + issued_cnt;
    assign outstanding_d = outstanding_q + issued_cnt - returned_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        launch  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_RUNNING: begin
                    if (match) begin
                        state_d = ST_FOUND;
                    end else if ((next_d > last_q) && (outstanding_d == '0)) begin
                        state_d = ST_EXHAUSTED;
                    end
                end
                default: begin
                    if (start) begin
                        launch  = 1'b1;
                        state_d = (nonce_first > nonce_last) ? ST_EXHAUSTED : ST_RUNNING;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next_q        <= '0;
            last_q        <= '0;
            outstanding_q <= '0;
            midstate_q    <= '0;
            tail_q        <= '0;
            target_q      <= '0;
            nonce_q       <= '0;
        end else if (launch) begin
            next_q        <= {1'b0, nonce_first};
            last_q        <= {1'b0, nonce_last};
            outstanding_q <= '0;
            midstate_q    <= midstate;
            tail_q        <= header_leftovers;
            target_q      <= target;
            nonce_q       <= '0;
        end else if (running) begin
            next_q        <= next_d;
            outstanding_q <= outstanding_d;
            if (match) begin
                nonce_q <= match_nonce;
            end
        end
    end

    assign state_out     = state;
    assign nonce         = nonce_q;
    assign core_midstate = midstate_q;
    assign core_tail     = tail_q;

endmodule

// File: tb/tb_block_solver_mc.sv
// Self-checking bench for block_solver_mc: directed corner cases plus randomized
// jobs checked against a queue-free arithmetic model of the dispatch rules.
module tb_block_solver_mc;

    localparam int NC = 4;
    localparam int NW = 32;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [255:0]      midstate, target;
    logic [95:0]       header_leftovers;
    logic [NW-1:0]     nonce_first, nonce_last;
    logic [1:0]        state_out;
    logic [NW-1:0]     nonce;
    logic [255:0]      core_midstate;
    logic [95:0]       core_tail;
    logic [NC-1:0]     core_valid, core_ready, res_valid;
    logic [NC*NW-1:0]  core_nonce, res_nonce;
    logic [NC*256-1:0] res_hash;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] NO_MATCH_TGT = {32'h8000_0000, 224'h0};

    always #5 clk = ~clk;

    block_solver_mc #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .midstate         (midstate),
        .header_leftovers (header_leftovers),
        .target           (target),
        .nonce_first      (nonce_first),
        .nonce_last       (nonce_last),
        .state_out        (state_out),
        .nonce            (nonce),
        .core_midstate    (core_midstate),
        .core_tail        (core_tail),
        .core_valid       (core_valid),
        .core_ready       (core_ready),
        .core_nonce       (core_nonce),
        .res_valid        (res_valid),
        .res_hash         (res_hash),
        .res_nonce        (res_nonce)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mix(input logic [31:0] n);
        return n * 32'h9E37_79B1;
    endfunction

    function automatic logic [255:0] hash_of(input logic [31:0] n);
        return {mix(n), 224'h1};
    endfunction

    task automatic launch(input logic [31:0] f, input logic [31:0] l, input logic [255:0] tgt);
        @(negedge clk);
        start       = 1'b1;
        abort       = 1'b0;
        nonce_first = f;
        nonce_last  = l;
        target      = tgt;
        for (int k = 0; k < 8; k++) midstate[k*32 +: 32] = $urandom();
        for (int k = 0; k < 3; k++) header_leftovers[k*32 +: 32] = $urandom();
        res_valid   = '0;
        core_ready  = '0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        midstate = '1; header_leftovers = '1; target = '1;
        nonce_first = '0; nonce_last = '1;
        core_ready = '1; res_valid = '0; res_hash = '0; res_nonce = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (state_out !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state_out); end
        checks++; if (nonce !== '0) begin errors++; $display("[TB] FAIL reset_nonce: got %0h expected 0", nonce); end
        checks++; if (core_valid !== '0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0000", core_valid); end
        checks++; if (core_midstate !== '0) begin errors++; $display("[TB] FAIL reset_midstate: got %0h expected 0", core_midstate); end
        checks++; if (core_tail !== '0) begin errors++; $display("[TB] FAIL reset_tail: got %0h expected 0", core_tail); end
        @(negedge clk);
        rst = 1'b0;
        core_ready = '0;
    endtask

    task automatic test_all_ready();
        launch(32'd0, 32'd11, NO_MATCH_TGT);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            core_ready = 4'hF;
            res_valid  = (c > 0) ? 4'hF : 4'h0;
            for (int i = 0; i < NC; i++) begin
                res_nonce[i*NW +: NW] = (c > 0) ? 32'(4 * (c - 1) + i) : 32'd0;
                res_hash[i*256 +: 256] = '1;
            end
            #1;
            checks++; if (state_out !== 2'd1) begin errors++; $display("[TB] FAIL all_ready_state c%0d: got %0d expected 1", c, state_out); end
            checks++; if (core_valid !== ((c < 3) ? 4'hF : 4'h0)) begin errors++; $display("[TB] FAIL all_ready_valid c%0d: got %b", c, core_valid); end
            if (c < 3) begin
                for (int i = 0; i < NC; i++) begin
                    checks++;
                    if (core_nonce[i*NW +: NW] !== 32'(4 * c + i)) begin
                        errors++; $display("[TB] FAIL all_ready_nonce c%0d core%0d: got %0h expected %0h", c, i, core_nonce[i*NW +: NW], 4 * c + i);
                    end
                end
            end
        end
        checks++; if (core_midstate !== midstate) begin errors++; $display("[TB] FAIL all_ready_midstate: got %0h expected %0h", core_midstate, midstate); end
        checks++; if (core_tail !== header_leftovers) begin errors++; $display("[TB] FAIL all_ready_tail: got %0h expected %0h", core_tail, header_leftovers); end
        @(negedge clk);
        res_valid = '0;
        #1;
        checks++; if (state_out !== 2'd3) begin errors++; $display("[TB] FAIL all_ready_exhausted: got %0d expected 3", state_out); end
        checks++; if (core_valid !== '0) begin errors++; $display("[TB] FAIL all_ready_idle_valid: got %b expected 0000", core_valid); end
    endtask

    task automatic test_sparse_ready();
        logic [NC-1:0] exp_v [4];
        logic [31:0]   exp_n1 [4];
        logic [31:0]   exp_n3 [4];
        exp_v[0] = 4'b1010; exp_n1[0] = 32'd5; exp_n3[0] = 32'd6;
        exp_v[1] = 4'b1010; exp_n1[1] = 32'd7; exp_n3[1] = 32'd8;
        exp_v[2] = 4'b0010; exp_n1[2] = 32'd9; exp_n3[2] = 32'd0;
        exp_v[3] = 4'b0000; exp_n1[3] = 32'd0; exp_n3[3] = 32'd0;
        launch(32'd5, 32'd9, NO_MATCH_TGT);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            core_ready  = 4'b1010;
            start       = (c == 1);
            nonce_first = 32'd0;
            nonce_last  = 32'd100;
            #1;
            checks++; if (core_valid !== exp_v[c]) begin errors++; $display("[TB] FAIL sparse_valid c%0d: got %b expected %b", c, core_valid, exp_v[c]); end
            if (exp_v[c][1]) begin
                checks++; if (core_nonce[1*NW +: NW] !== exp_n1[c]) begin errors++; $display("[TB] FAIL sparse_core1 c%0d: got %0d expected %0d", c, core_nonce[1*NW +: NW], exp_n1[c]); end
            end
            if (exp_v[c][3]) begin
                checks++; if (core_nonce[3*NW +: NW] !== exp_n3[c]) begin errors++; $display("[TB] FAIL sparse_core3 c%0d: got %0d expected %0d", c, core_nonce[3*NW +: NW], exp_n3[c]); end
            end
        end
        checks++; if (state_out !== 2'd1) begin errors++; $display("[TB] FAIL sparse_waiting: got %0d expected 1", state_out); end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        #1;
        checks++; if (core_valid !== '0) begin errors++; $display("[TB] FAIL sparse_abort_valid: got %b expected 0000", core_valid); end
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++; if (state_out !== 2'd0) begin errors++; $display("[TB] FAIL sparse_abort_state: got %0d expected 0", state_out); end
    endtask

    task automatic test_match_priority();
        launch(32'd0, 32'd1000, NO_MATCH_TGT);
        core_ready = 4'hF;
        #1;
        checks++; if (core_valid !== 4'hF) begin errors++; $display("[TB] FAIL match_issue: got %b expected 1111", core_valid); end
        @(negedge clk);
        res_valid = 4'b0101;
        res_hash  = '1;
        res_nonce = '0;
        res_hash[0*256 +: 256] = '0;  res_nonce[0*NW +: NW] = 32'h20;
        res_hash[2*256 +: 256] = '0;  res_nonce[2*NW +: NW] = 32'h10;
        #1;
        checks++; if (core_valid !== '0) begin errors++; $display("[TB] FAIL match_stop_issue: got %b expected 0000", core_valid); end
        @(negedge clk);
        res_valid = 4'b0010;
        res_hash[1*256 +: 256] = '0;  res_nonce[1*NW +: NW] = 32'h55;
        #1;
        checks++; if (state_out !== 2'd2) begin errors++; $display("[TB] FAIL match_state: got %0d expected 2", state_out); end
        checks++; if (nonce !== 32'h20) begin errors++; $display("[TB] FAIL match_nonce: got %0h expected 20", nonce); end
        @(negedge clk);
        res_valid = '0;
        #1;
        checks++; if (nonce !== 32'h20) begin errors++; $display("[TB] FAIL found_ignores_results: got %0h expected 20", nonce); end
        checks++; if (state_out !== 2'd2) begin errors++; $display("[TB] FAIL found_hold: got %0d expected 2", state_out); end
    endtask

    task automatic test_top_range();
        launch(32'hFFFF_FFFE, 32'hFFFF_FFFF, NO_MATCH_TGT);
        core_ready = 4'hF;
        #1;
        checks++; if (core_valid !== 4'b0011) begin errors++; $display("[TB] FAIL top_valid: got %b expected 0011", core_valid); end
        checks++; if (core_nonce[0 +: NW] !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL top_core0: got %0h expected fffffffe", core_nonce[0 +: NW]); end
        checks++; if (core_nonce[NW +: NW] !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL top_core1: got %0h expected ffffffff", core_nonce[NW +: NW]); end
        @(negedge clk);
        res_valid = 4'b0011;
        res_hash  = '1;
        res_nonce = '0;
        res_nonce[0 +: NW]  = 32'hFFFF_FFFE;
        res_nonce[NW +: NW] = 32'hFFFF_FFFF;
        #1;
        checks++; if (core_valid !== '0) begin errors++; $display("[TB] FAIL top_no_wrap: got %b expected 0000", core_valid); end
        checks++; if (state_out !== 2'd1) begin errors++; $display("[TB] FAIL top_running: got %0d expected 1", state_out); end
        @(negedge clk);
        res_valid = '0;
        #1;
        checks++; if (state_out !== 2'd3) begin errors++; $display("[TB] FAIL top_exhausted: got %0d expected 3", state_out); end
        checks++; if (core_valid !== '0) begin errors++; $display("[TB] FAIL top_after_valid: got %b expected 0000", core_valid); end
    endtask

    task automatic test_empty_range();
        launch(32'd10, 32'd3, NO_MATCH_TGT);
        core_ready = 4'hF;
        #1;
        checks++; if (state_out !== 2'd3) begin errors++; $display("[TB] FAIL empty_state: got %0d expected 3", state_out); end
        checks++; if (core_valid !== '0) begin errors++; $display("[TB] FAIL empty_valid: got %b expected 0000", core_valid); end
        @(negedge clk);
        #1;
        checks++; if (core_valid !== '0) begin errors++; $display("[TB] FAIL empty_valid_hold: got %b expected 0000", core_valid); end
    endtask

    task automatic test_abort_start();
        launch(32'd0, 32'd50, NO_MATCH_TGT);
        core_ready = 4'hF;
        #1;
        checks++; if (core_valid !== 4'hF) begin errors++; $display("[TB] FAIL abort_pre_valid: got %b expected 1111", core_valid); end
        @(negedge clk);
        abort = 1'b1; start = 1'b1; nonce_first = 32'd0; nonce_last = 32'd5;
        #1;
        checks++; if (core_valid !== '0) begin errors++; $display("[TB] FAIL abort_drop_valid: got %b expected 0000", core_valid); end
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        #1;
        checks++; if (state_out !== 2'd0) begin errors++; $display("[TB] FAIL abort_beats_start: got %0d expected 0", state_out); end
        checks++; if (core_valid !== '0) begin errors++; $display("[TB] FAIL abort_idle_valid: got %b expected 0000", core_valid); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (state_out !== 2'd0) begin errors++; $display("[TB] FAIL rst_state: got %0d expected 0", state_out); end
        checks++; if (core_midstate !== '0) begin errors++; $display("[TB] FAIL rst_midstate: got %0h expected 0", core_midstate); end
        checks++; if (core_tail !== '0) begin errors++; $display("[TB] FAIL rst_tail: got %0h expected 0", core_tail); end
        checks++; if (nonce !== '0) begin errors++; $display("[TB] FAIL rst_nonce: got %0h expected 0", nonce); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (core_valid !== '0) begin errors++; $display("[TB] FAIL rst_release_valid: got %b expected 0000", core_valid); end
        checks++; if (state_out !== 2'd0) begin errors++; $display("[TB] FAIL rst_release_state: got %0d expected 0", state_out); end
    endtask

    // Model: ready cores in index order take next, next+1, ... up to last; results
    // come back one cycle after issue; the lowest-index winner ends the job.
    task automatic test_random(input int jobs);
        for (int j = 0; j < jobs; j++) begin
            longint unsigned mnext, mlast;
            int              outst, rank, issued, cyc;
            logic [NC-1:0]   pv, ev;
            logic [31:0]     pn [NC];
            logic [31:0]     en [NC];
            logic [31:0]     thr, first, exp_nonce;
            bit              found, done;

            if ($urandom_range(0, 3) == 0) first = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
            else                           first = 32'($urandom_range(0, 1000));
            mlast = longint'(first) + longint'($urandom_range(0, 14));
            if (mlast > 64'hFFFF_FFFF) mlast = 64'hFFFF_FFFF;
            thr = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(0, 32'h4000_0000));
            launch(first, 32'(mlast), {thr, 224'h0});

            mnext = longint'(first);
            outst = 0; pv = '0; found = 1'b0; done = 1'b0; cyc = 0; exp_nonce = '0;
            for (int i = 0; i < NC; i++) pn[i] = '0;
            while (!done) begin
                if (cyc > 0) @(negedge clk);
                core_ready = 4'($urandom_range(0, 15));
                res_valid  = pv;
                for (int i = 0; i < NC; i++) begin
                    res_nonce[i*NW +: NW]  = pn[i];
                    res_hash[i*256 +: 256] = hash_of(pn[i]);
                end
                found = 1'b0;
                for (int i = NC - 1; i >= 0; i--) begin
                    if (pv[i] && (mix(pn[i]) < thr)) begin
                        found = 1'b1;
                        exp_nonce = pn[i];
                    end
                end
                ev = '0; rank = 0; issued = 0;
                for (int i = 0; i < NC; i++) en[i] = '0;
                if (!found) begin
                    for (int i = 0; i < NC; i++) begin
                        if (core_ready[i]) begin
                            if (mnext + longint'(rank) <= mlast) begin
                                ev[i] = 1'b1;
                                en[i] = 32'(mnext + longint'(rank));
                                issued++;
                            end
                            rank++;
                        end
                    end
                end
                #1;
                checks++; if (state_out !== 2'd1) begin errors++; $display("[TB] FAIL rand_state j%0d c%0d: got %0d expected 1", j, cyc, state_out); end
                checks++; if (core_valid !== ev) begin errors++; $display("[TB] FAIL rand_valid j%0d c%0d: got %b expected %b", j, cyc, core_valid, ev); end
                for (int i = 0; i < NC; i++) begin
                    if (ev[i]) begin
                        checks++;
                        if (core_nonce[i*NW +: NW] !== en[i]) begin
                            errors++; $display("[TB] FAIL rand_nonce j%0d c%0d core%0d: got %0h expected %0h", j, cyc, i, core_nonce[i*NW +: NW], en[i]);
                        end
                    end
                end
                mnext += longint'(issued);
                outst += issued - $countones(pv);
                pv = ev;
                pn = en;
                cyc++;
                if (found || (mnext > mlast && outst == 0)) begin
                    done = 1'b1;
                end else if (cyc > 200) begin
                    checks++; errors++;
                    $display("[TB] FAIL rand_timeout j%0d: job did not finish within 200 cycles", j);
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    done = 1'b1;
                end
            end
            @(negedge clk);
            res_valid = '0; core_ready = '0;
            #1;
            checks++;
            if (state_out !== (found ? 2'd2 : 2'd3)) begin
                errors++; $display("[TB] FAIL rand_end_state j%0d: got %0d expected %0d", j, state_out, found ? 2 : 3);
            end
            if (found) begin
                checks++;
                if (nonce !== exp_nonce) begin
                    errors++; $display("[TB] FAIL rand_win_nonce j%0d: got %0h expected %0h", j, nonce, exp_nonce);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ready();
        test_sparse_ready();
        test_match_priority();
        test_top_range();
        test_empty_range();
        test_abort_start();
        test_random(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
